// File: rtl/bsg_manycore_cache_req_arbiter.sv
// Round-robin arbiter sharing one bsg_cache port among num_req_p requesters, with burst locking
// and an in-order ID tracker for response routing. Optional: BSG_MANYCORE_CACHE_ARB_LOCK_LIMIT_EN.
module bsg_manycore_cache_req_arbiter #(
    parameter int num_req_p         = 2,
    parameter int cache_pkt_width_p = 16,
    parameter int data_width_p      = 32,
    parameter int fifo_els_p        = 4,
    parameter int max_lock_grants_p = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_req_p*cache_pkt_width_p-1:0] pkt_i,
    input  logic [num_req_p-1:0]                   v_i,
    input  logic [num_req_p-1:0]                   lock_i,
    output logic [num_req_p-1:0]                   yumi_o,
    output logic [cache_pkt_width_p-1:0]           cache_pkt_o,
    output logic                                   cache_v_o,
    input  logic                                   cache_yumi_i,
    input  logic [data_width_p-1:0]                cache_data_i,
    input  logic                                   cache_v_i,
    output logic                                   cache_yumi_o,
    output logic [data_width_p-1:0]                data_o,
    output logic [num_req_p-1:0]                   v_o,
    input  logic [num_req_p-1:0]                   yumi_i,
    output logic [$clog2(num_req_p)-1:0]           grant_id_o
);
    localparam int ID_W  = $clog2(num_req_p);
    localparam int PTR_W = $clog2(fifo_els_p);
    localparam int CNT_W = $clog2(fifo_els_p + 1);

    logic [ID_W-1:0]  r_last, r_owner;
    logic             r_locked;
    logic [ID_W-1:0]  r_mem [fifo_els_p];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;

    logic [ID_W-1:0]  w_rr_g, w_g, w_head;
    logic             w_rr_found, w_empty, w_pop, w_push, w_can_issue, w_release, w_limit;

    // Round-robin scan starting just past the last granted requester.
    always_comb begin
        int idx;
        idx        = 0;
        w_rr_g     = '0;
        w_rr_found = 1'b0;
        for (int i = 1; i <= num_req_p; i++) begin
            idx = (int'(r_last) + i) % num_req_p;
            if (!w_rr_found && v_i[idx]) begin
                w_rr_found = 1'b1;
                w_rr_g     = ID_W'(idx);
            end
        end
    end

    assign w_g         = r_locked ? r_owner : w_rr_g;
    assign grant_id_o  = w_g;
    assign cache_pkt_o = pkt_i[w_g*cache_pkt_width_p +: cache_pkt_width_p];

    assign w_empty      = (r_count == '0);
    assign w_head       = r_mem[r_rptr];
    assign cache_yumi_o = cache_v_i & yumi_i[w_head] & ~w_empty;
    assign w_pop        = cache_yumi_o;
    assign data_o       = cache_data_i;

    // A same-cycle pop frees a slot, so a full tracker can still accept.
    assign w_can_issue = (r_count < CNT_W'(fifo_els_p)) | w_pop;
    assign cache_v_o   = v_i[w_g] & w_can_issue;
    assign w_push      = cache_yumi_i & cache_v_o;
    assign w_release   = r_locked & ~v_i[r_owner] & ~lock_i[r_owner];

    always_comb begin
        yumi_o        = '0;
        yumi_o[w_g]   = cache_yumi_i;
        v_o           = '0;
        v_o[w_head]   = cache_v_i & ~w_empty;
    end

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < fifo_els_p; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_g;
                r_wptr        <= f_next(r_wptr);
            end
            if (w_pop) r_rptr <= f_next(r_rptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_last   <= ID_W'(num_req_p - 1);
            r_locked <= 1'b0;
            r_owner  <= '0;
        end else if (w_push) begin
            r_last <= w_g;
            if (lock_i[w_g] && !w_limit) begin
                r_locked <= 1'b1;
                r_owner  <= w_g;
            end else begin
                r_locked <= 1'b0;
            end
        end else if (w_release) begin
            r_locked <= 1'b0;
        end
    end

`ifdef BSG_MANYCORE_CACHE_ARB_LOCK_LIMIT_EN
    localparam int LC_W = $clog2(max_lock_grants_p + 1);
    logic [LC_W-1:0] r_lock_cnt;

    // Counts locking accepts; the one that hits the limit drops the lock.
    assign w_limit = (r_lock_cnt == LC_W'(max_lock_grants_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                    r_lock_cnt <= '0;
        else if (w_push) begin
            if (lock_i[w_g] && !w_limit)   r_lock_cnt <= r_lock_cnt + 1'b1;
            else                           r_lock_cnt <= '0;
        end else if (w_release)            r_lock_cnt <= '0;
    end
`else
    assign w_limit = 1'b0;
`endif

    // Protocol checks, simulation only in effect.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (num_req_p >= 2 && fifo_els_p >= 2 && max_lock_grants_p >= 1)
                else $error("bad parameters");
            assert (!(cache_v_i && w_empty)) else $error("cache response with empty tracker");
            assert (!(cache_yumi_i && !cache_v_o)) else $error("cache_yumi_i without cache_v_o");
        end
    end
endmodule

// File: tb/tb_bsg_manycore_cache_req_arbiter.sv
// Directed bench for bsg_manycore_cache_req_arbiter; response IDs checked against a queue scoreboard.
module tb_bsg_manycore_cache_req_arbiter;
    localparam logic [15:0] PKT0 = 16'hA000;
    localparam logic [15:0] PKT1 = 16'hB111;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [31:0] pkt_i;
    logic [1:0]  v_i, lock_i, yumi_o, v_o, yumi_i;
    logic [15:0] cache_pkt_o;
    logic        cache_v_o, cache_yumi_i, cache_v_i, cache_yumi_o;
    logic [31:0] cache_data_i, data_o;
    logic [0:0]  grant_id_o;
    logic        yumi_en;

    int errs   = 0;
    int checks = 0;
    int q[$];

    bsg_manycore_cache_req_arbiter #(
        .num_req_p(2), .cache_pkt_width_p(16), .data_width_p(32),
        .fifo_els_p(4), .max_lock_grants_p(8)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .pkt_i(pkt_i), .v_i(v_i), .lock_i(lock_i),
        .yumi_o(yumi_o), .cache_pkt_o(cache_pkt_o), .cache_v_o(cache_v_o),
        .cache_yumi_i(cache_yumi_i), .cache_data_i(cache_data_i), .cache_v_i(cache_v_i),
        .cache_yumi_o(cache_yumi_o), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
        .grant_id_o(grant_id_o)
    );

    always #5 clk_i = ~clk_i;

    // The cache side accepts whenever enabled and a packet is offered.
    assign cache_yumi_i = yumi_en & cache_v_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, update scoreboard.
    task automatic step(input string tag, input logic [1:0] v, input logic [1:0] lk, input bit yen,
                        input bit resp, input logic [1:0] ry, input int exp_g, input bit exp_cv);
        int h;
        @(negedge clk_i);
        v_i          = v;
        lock_i       = lk;
        yumi_en      = yen;
        yumi_i       = ry;
        cache_data_i = $urandom;
        cache_v_i    = resp && (q.size() > 0);
        #1;
        chk({tag, "_gid"}, 32'(grant_id_o), 32'(exp_g));
        chk({tag, "_cv"}, 32'(cache_v_o), 32'(exp_cv));
        chk({tag, "_yumi"}, 32'(yumi_o), (exp_cv && yen) ? (32'd1 << exp_g) : 32'd0);
        chk({tag, "_pkt"}, 32'(cache_pkt_o), 32'(exp_g == 1 ? PKT1 : PKT0));
        if (cache_v_i) begin
            h = q[0];
            chk({tag, "_vo"}, 32'(v_o), 32'd1 << h);
            chk({tag, "_cyumi"}, 32'(cache_yumi_o), 32'(ry[h]));
            chk({tag, "_data"}, data_o, cache_data_i);
            if (ry[h]) void'(q.pop_front());
        end else begin
            chk({tag, "_vo0"}, 32'(v_o), 32'd0);
            chk({tag, "_cyumi0"}, 32'(cache_yumi_o), 32'd0);
        end
        if (exp_cv && yen) q.push_back(exp_g);
    endtask

    initial begin
        int eg;
        pkt_i = {PKT1, PKT0};
        reset_n_i = 1'b0;
        v_i = '0; lock_i = '0; yumi_en = 1'b0; yumi_i = '0;
        cache_v_i = 1'b0; cache_data_i = '0;
        #12;
        chk("rst_gid", 32'(grant_id_o), 0);
        chk("rst_cv", 32'(cache_v_o), 0);
        chk("rst_yumi", 32'(yumi_o), 0);
        chk("rst_vo", 32'(v_o), 0);
        chk("rst_cyumi", 32'(cache_yumi_o), 0);
        chk("rst_data", data_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Alternating grants until the tracker fills.
        step("rr0", 2'b11, 2'b00, 1, 0, 2'b00, 0, 1);
        step("rr1", 2'b11, 2'b00, 1, 0, 2'b00, 1, 1);
        step("rr2", 2'b11, 2'b00, 1, 0, 2'b00, 0, 1);
        step("rr3", 2'b11, 2'b00, 1, 0, 2'b00, 1, 1);
        step("full", 2'b11, 2'b00, 1, 0, 2'b00, 0, 0);
        step("full_pop", 2'b11, 2'b00, 1, 1, 2'b11, 0, 1);
        step("still_full", 2'b11, 2'b00, 1, 0, 2'b00, 1, 0);

        // Response stalled by the wrong requester's yumi.
        for (int k = 0; k < 3; k++) step("stall", 2'b00, 2'b00, 0, 1, 2'b01, 0, 0);
        for (int k = 0; k < 4; k++) step("drain", 2'b00, 2'b00, 0, 1, 2'b11, 0, 0);
        step("idle", 2'b00, 2'b00, 0, 1, 2'b11, 0, 0);

        // Burst lock: 4 grants to 0, then 1.
        step("pre", 2'b10, 2'b00, 1, 1, 2'b11, 1, 1);
        step("lk1", 2'b11, 2'b01, 1, 1, 2'b11, 0, 1);
        step("lk2", 2'b11, 2'b01, 1, 1, 2'b11, 0, 1);
        step("lk3", 2'b11, 2'b01, 1, 1, 2'b11, 0, 1);
        step("lk4", 2'b11, 2'b00, 1, 1, 2'b11, 0, 1);
        step("lk5", 2'b11, 2'b00, 1, 1, 2'b11, 1, 1);
        step("lk6", 2'b11, 2'b00, 1, 1, 2'b11, 0, 1);

        // Lock holds off requester 1 while the owner idles, then releases.
        step("rl0", 2'b11, 2'b00, 1, 1, 2'b11, 1, 1);
        step("rl1", 2'b11, 2'b01, 1, 1, 2'b11, 0, 1);
        step("block", 2'b10, 2'b01, 1, 1, 2'b11, 0, 0);
        step("release", 2'b10, 2'b00, 0, 1, 2'b11, 0, 0);
        step("after_rel", 2'b10, 2'b00, 1, 1, 2'b11, 1, 1);

        // Long lock: limited only when the lock-limit feature is built in.
        for (int k = 0; k < 9; k++) begin
`ifdef BSG_MANYCORE_CACHE_ARB_LOCK_LIMIT_EN
            eg = (k < 8) ? 0 : 1;
`else
            eg = 0;
`endif
            step("longlock", 2'b11, 2'b01, 1, 1, 2'b11, eg, 1);
        end
        step("ll_rel", 2'b00, 2'b00, 0, 1, 2'b11, 0, 0);

        // Reset mid-burst with two outstanding IDs.
        step("mb0", 2'b01, 2'b01, 1, 0, 2'b00, 0, 1);
        step("mb1", 2'b01, 2'b01, 1, 0, 2'b00, 0, 1);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        v_i = '0; lock_i = '0; yumi_en = 1'b0; cache_v_i = 1'b0;
        #1;
        chk("mrst_gid", 32'(grant_id_o), 0);
        chk("mrst_vo", 32'(v_o), 0);
        chk("mrst_cv", 32'(cache_v_o), 0);
        q.delete();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step("post_rst", 2'b10, 2'b00, 1, 0, 2'b00, 1, 1);
        step("post_resp", 2'b00, 2'b00, 0, 1, 2'b11, 0, 0);
        step("post_rr", 2'b11, 2'b00, 1, 0, 2'b00, 0, 1);
        chk("sb_len", 32'(q.size()), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/bsg_manycore_cache_req_arbiter.md
Name: bsg_manycore_cache_req_arbiter

Overview:
- Shares one bsg_cache request/response port among num_req_p link-to-cache requesters, for example a manycore-side adapter and a DMA/host adapter.
- Round-robin arbitration on the request side, with grant locking so that multi-packet bursts (icache block fetch) stay unbroken.
- An in-order ID tracker routes each cache response back to the requester that issued it.
- Sits between the adapters and the bsg_cache instance in the cache tile.

Parameters:
- num_req_p, 2, number of requesters (>=2).
- cache_pkt_width_p, (none), width of bsg_cache_pkt_s.
- data_width_p, 32, cache data width.
- fifo_els_p, 4, max outstanding accepted-but-unreturned packets (>=2).
- max_lock_grants_p, 8, burst limit, used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- pkt_i  in  num_req_p*cache_pkt_width_p  per-requester cache packets; requester r occupies slice r.
- v_i  in  num_req_p  per-requester packet valid.
- lock_i  in  num_req_p  hold grant after this packet is accepted.
- yumi_o  out  num_req_p  packet accepted by cache.
- cache_pkt_o  out  cache_pkt_width_p  muxed packet to cache.
- cache_v_o  out  1  packet valid to cache.
- cache_yumi_i  in  1  cache accepts packet.
- cache_data_i  in  data_width_p  cache response data.
- cache_v_i  in  1  cache response valid.
- cache_yumi_o  out  1  response consumed.
- data_o  out  data_width_p  response data, broadcast to all requesters.
- v_o  out  num_req_p  response valid, one-hot to the owning requester.
- yumi_i  in  num_req_p  requester consumes response.
- grant_id_o  out  lg(num_req_p)  current grant index (debug).

Behaviour:
- Single clock domain. reset_n_i is asynchronous and active-low; all state clears on its assertion.
- Reset values:
  - last_r = num_req_p-1, so requester 0 has first priority.
  - locked_r = 0, owner_r = 0.
  - tracker empty, count_r = 0, lock_cnt_r = 0.
- All outputs are combinational from state and inputs. With all v_i=0 and cache_v_i=0, every output is 0 (cache_pkt_o is don't-care but driven with slice 0).
- Grant, unlocked: the first r with v_i[r]=1, scanning last_r+1 upward with wrap modulo num_req_p.
- Grant, locked: g = owner_r only. Other requesters are blocked even if owner_r has v_i=0.
- can_issue = (count_r < fifo_els_p) OR (response pop this cycle).
- cache_v_o = v_i[g] & can_issue.
- cache_pkt_o = pkt_i slice g.
- yumi_o[g] = cache_yumi_i; all other yumi_o bits = 0. Zero-latency pass-through.
- On accept (cache_yumi_i=1):
  - push g into the tracker; last_r <= g.
  - if lock_i[g]=1: locked_r <= 1, owner_r <= g.
  - else: locked_r <= 0.
- Lock release without accept: while locked_r=1, if v_i[owner_r]=0 and lock_i[owner_r]=0, then locked_r <= 0 on the next edge.
- Response routing:
  - head id h = tracker head.
  - v_o[h] = cache_v_i & ~empty.
  - data_o = cache_data_i.
  - cache_yumi_o = cache_v_i & yumi_i[h] & ~empty.
  - pop on cache_yumi_o.
- Simultaneous push and pop: count_r unchanged. Legal when full, because can_issue accounts for the pop.
- Tracker wrap-around: read and write pointers wrap modulo fifo_els_p.
- cache_v_i while tracker empty is a protocol error:
  - simulation assertion `$error` fires.
  - v_o = 0 and cache_yumi_o = 0.
- Reset asserted mid-burst: lock, pointers and outstanding IDs are discarded. The cache and requesters are reset by the same reset_n_i.
- yumi_o is never asserted without cache_yumi_i. cache_yumi_i while cache_v_o=0 is a protocol error (assertion).

Optional Feature:
- Macro: BSG_MANYCORE_CACHE_ARB_LOCK_LIMIT_EN.
- Defined:
  - lock_cnt_r counts consecutive accepts under lock; it resets to 0 when locked_r clears.
  - When lock_cnt_r reaches max_lock_grants_p-1 and an accept occurs, locked_r is forced to 0 regardless of lock_i, and last_r advances normally.
  - Other requesters therefore compete on the next cycle.
- Not defined: lock persists until released as above; lock_cnt_r does not exist.

Test Plan:
- Both requesters continuously valid, lock_i=0, cache_yumi_i=1 every cycle -> grants alternate 0,1,0,1; response IDs come back in the same order; v_o one-hot matches.
- Requester 0 issues 4 packets with lock_i=1,1,1,0 while requester 1 is valid -> 4 consecutive grants to 0, then grant to 1.
- fifo_els_p=4, cache_v_i held 0, 5 requests -> 4 accepted, cache_v_o=0 on the 5th. Assert cache_v_i with yumi_i[h]=1 in the same cycle -> 5th accepted, count stays 4.
- Responses with yumi_i low for 3 cycles -> cache_yumi_o=0 and v_o held; data_o tracks cache_data_i; no pop.
- Assert reset_n_i=0 mid-burst with locked_r=1 and 2 outstanding -> next cycle grant_id_o=0, all v_o=0, tracker empty.
- Macro defined, max_lock_grants_p=3, requester 0 holds lock_i=1 -> after 3 accepts requester 1 is granted. Macro undefined -> requester 0 keeps the grant indefinitely.
